// File: rtl/apb4_ram_slave.sv
// -----------------------------------------------------------------------------
// apb4_ram_slave
//   APB4 completer backed by an on-chip word RAM with byte-lane writes,
//   address range/alignment error reporting and programmable wait states.
//
//   Parameters:
//     ADDR_WIDTH   PADDR width (byte address)
//     DATA_WIDTH   PWDATA/PRDATA width (8, 16, 32 or 64)
//     MEM_DEPTH    number of DATA_WIDTH words (power of two)
//     BASE_ADDR    byte address of word 0 (DATA_WIDTH/8 aligned)
//     WAIT_CYCLES  wait states per transfer (0..15)
//     SECURE_WORDS words [0..SECURE_WORDS-1] are secure-only (protection check)
//
//   Optional feature macro: APB_PROT_CHECK_EN
//     defined   -> non-secure access (PPROT[1]=1) to a secure word errors
//     undefined -> PPROT is ignored
//
//   Ports:
//     PCLK, PRESETn          clock, asynchronous active-low reset
//     PSEL, PENABLE, PWRITE  APB4 control
//     PADDR, PWDATA, PSTRB   address, write data, write byte strobes
//     PPROT                  protection attributes
//     PREADY, PSLVERR        registered completion / error response
//     PRDATA                 registered read data (holds until next completion)
// -----------------------------------------------------------------------------
module apb4_ram_slave #(
  parameter int unsigned             ADDR_WIDTH   = 32,
  parameter int unsigned             DATA_WIDTH   = 32,
  parameter int unsigned             MEM_DEPTH    = 256,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR    = '0,
  parameter int unsigned             WAIT_CYCLES  = 0,
  parameter int unsigned             SECURE_WORDS = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int unsigned STRB_W   = DATA_WIDTH / 8;
  localparam int unsigned ADDR_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;

  logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];
  logic                    mem_we;

  // ---------------------------------------------------------------------------
  // Address decode and error terms (from the live bus)
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] word_off;
  logic [IDX_W-1:0]      idx;
  logic                  below_base;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  err_addr;
  logic                  err_prot;
  logic                  err;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_sig;

  assign off          = PADDR - BASE_ADDR;
  assign below_base   = (PADDR < BASE_ADDR);
  assign word_off     = off >> ADDR_LSB;
  assign out_of_range = (word_off >= ADDR_WIDTH'(MEM_DEPTH));
  assign misaligned   = ((off & ADDR_WIDTH'(STRB_W - 1)) != '0);
  assign idx          = word_off[IDX_W-1:0];
  assign err_addr     = below_base | out_of_range | misaligned;

`ifdef APB_PROT_CHECK_EN
  assign err_prot   = PPROT[1] & (word_off < ADDR_WIDTH'(SECURE_WORDS));
  assign unused_sig = ^{PPROT[2], PPROT[0]};
`else
  localparam logic [31:0] SEC_UNUSED = 32'(SECURE_WORDS);
  assign err_prot   = 1'b0;
  assign unused_sig = ^{PPROT, SEC_UNUSED[0]};
`endif

  // A read carrying any strobe is a protocol error in APB4.
  assign err     = err_addr | err_prot | (~PWRITE & (PSTRB != '0));
  assign rd_word = mem_q[idx];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          if (WAIT_CYCLES == 0) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_READY: begin
        // Completion (PSEL & PENABLE) or abandoned transfer (!PSEL).
        if (!PSEL || PENABLE) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath logic
  // Response registers are loaded on the edge that enters READY, so PREADY is
  // already high during the access cycle that completes the transfer.
  // ---------------------------------------------------------------------------
  logic enter_ready;
  logic leave_ready;

  assign enter_ready = (state_d == ST_READY) && (state_q != ST_READY);
  assign leave_ready = (state_q == ST_READY) && (state_d == ST_IDLE);

  always_comb begin
    pready_d  = pready_q;
    pslverr_d = pslverr_q;
    prdata_d  = prdata_q;
    mem_we    = 1'b0;
    if (enter_ready) begin
      pready_d  = 1'b1;
      pslverr_d = err;
      prdata_d  = (!PWRITE && !err) ? rd_word : '0;
    end
    if (leave_ready) begin
      pready_d  = 1'b0;
      pslverr_d = 1'b0;
      mem_we    = PSEL & PENABLE & PWRITE & ~err;
    end
  end

  // RAM contents are deliberately not reset.
  always_ff @(posedge PCLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (PSTRB[b]) begin
          mem_q[idx][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule
